// File: rtl/muovi_posizione.sv
// Frame-stepped X/Y position register driven by four push-buttons, with toroidal wrap at H/V.
// Optional macro MUOVI_POSIZIONE_ACCEL_EN doubles the step after 16 consecutive moving ticks.

module muovi_posizione_asse #(
  parameter int MODULO = 1280,
  parameter int INIT   = 590,
  parameter int PASSO  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        centra,
  input  logic        inc,
  input  logic        dec,
  output logic [10:0] pos,
  output logic        cambia
);
  localparam logic [11:0] MOD12  = 12'(MODULO);
  localparam logic [11:0] P1     = 12'(PASSO);
  localparam logic [10:0] INIT11 = 11'(INIT);

  logic        muove;
  logic [11:0] passo, pos12, nxt;
  logic        unused_msb;

  assign muove      = inc ^ dec;
  assign unused_msb = nxt[11];

`ifdef MUOVI_POSIZIONE_ACCEL_EN
  localparam logic [11:0] P2 = 12'(2 * PASSO);
  logic [4:0] cnt;
  logic       dir_inc;
  logic       inverte;

  // A reversal restarts the run: this tick moves at base step and counts as its first move.
  assign inverte = (cnt != 5'd0) && (dir_inc != inc);
  assign passo   = (cnt == 5'd16 && !inverte) ? P2 : P1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 5'd0;
      dir_inc <= 1'b0;
    end else if (centra) begin
      cnt <= 5'd0;
    end else if (tick) begin
      if (!muove) begin
        cnt <= 5'd0;
      end else begin
        dir_inc <= inc;
        cnt     <= inverte ? 5'd1 : ((cnt == 5'd16) ? 5'd16 : cnt + 5'd1);
      end
    end
  end
`else
  assign passo = P1;
`endif

  always_comb begin
    pos12 = {1'b0, pos};
    nxt   = pos12;
    if (inc && !dec) begin
      nxt = pos12 + passo;
      if (nxt >= MOD12) nxt = nxt - MOD12;
    end else if (dec && !inc) begin
      nxt = (pos12 >= passo) ? pos12 - passo : pos12 + MOD12 - passo;
    end
  end

  assign cambia = centra ? (pos != INIT11) : (tick && muove);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pos <= INIT11;
    else if (centra) pos <= INIT11;
    else if (tick)   pos <= nxt[10:0];
  end
endmodule

module muovi_posizione #(
  parameter int H      = 1280,
  parameter int V      = 1024,
  parameter int X_INIT = 590,
  parameter int Y_INIT = 462,
  parameter int PASSO  = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FRAME_TICK,
  input  logic        BTN_SU,
  input  logic        BTN_GIU,
  input  logic        BTN_SX,
  input  logic        BTN_DX,
  input  logic        CENTRA,
  output logic [10:0] X_POS,
  output logic [10:0] Y_POS,
  output logic        MOSSO
);
  // Bit order {su, giu, sx, dx}; sync_b is the stable copy used at the update edge.
  logic [3:0] sync_a, sync_b;
  logic       cambia_x, cambia_y;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_a <= 4'd0;
      sync_b <= 4'd0;
    end else begin
      sync_a <= {BTN_SU, BTN_GIU, BTN_SX, BTN_DX};
      sync_b <= sync_a;
    end
  end

  muovi_posizione_asse #(.MODULO(H), .INIT(X_INIT), .PASSO(PASSO)) asse_x (
    .clk(CLK), .rst_n(RST_N), .tick(FRAME_TICK), .centra(CENTRA),
    .inc(sync_b[0]), .dec(sync_b[1]), .pos(X_POS), .cambia(cambia_x)
  );

  muovi_posizione_asse #(.MODULO(V), .INIT(Y_INIT), .PASSO(PASSO)) asse_y (
    .clk(CLK), .rst_n(RST_N), .tick(FRAME_TICK), .centra(CENTRA),
    .inc(sync_b[2]), .dec(sync_b[3]), .pos(Y_POS), .cambia(cambia_y)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) MOSSO <= 1'b0;
    else        MOSSO <= cambia_x | cambia_y;
  end
endmodule

// File: tb/tb_muovi_posizione.sv
// Bench for muovi_posizione: directed wrap/priority/sync cases plus random stimulus vs a modular-arithmetic model.
module tb_muovi_posizione;
  localparam int H = 1280, V = 1024, XI = 590, YI = 462, P = 4;
`ifdef MUOVI_POSIZIONE_ACCEL_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  localparam logic [3:0] B_DX = 4'b0001, B_SX = 4'b0010, B_GIU = 4'b0100, B_SU = 4'b1000;

  logic CLK = 1'b0;
  logic RST_N, FRAME_TICK, BTN_SU, BTN_GIU, BTN_SX, BTN_DX, CENTRA;
  logic [10:0] X_POS, Y_POS;
  logic MOSSO;

  int total = 0, bad = 0;
  int mx, my, runx, runy, dirx, diry;
  logic mm;
  logic [3:0] p1, p2;

  always #5 CLK = ~CLK;

  muovi_posizione dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME_TICK(FRAME_TICK), .BTN_SU(BTN_SU), .BTN_GIU(BTN_GIU),
    .BTN_SX(BTN_SX), .BTN_DX(BTN_DX), .CENTRA(CENTRA), .X_POS(X_POS), .Y_POS(Y_POS), .MOSSO(MOSSO)
  );

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int step_of(input int run, input int dprev, input int d);
    return (ACC && run >= 16 && dprev == d) ? 2 * P : P;
  endfunction

  task automatic model_reset;
    mx = XI; my = YI; mm = 1'b0; p1 = 4'd0; p2 = 4'd0;
    runx = 0; runy = 0; dirx = 0; diry = 0;
  endtask

  // Buttons take effect two edges after being applied; a run counts consecutive same-direction moving ticks.
  task automatic model_edge(input logic [3:0] btn, input logic tick, input logic cen);
    int dx, dy;
    dx = int'(p2[0]) - int'(p2[1]);
    dy = int'(p2[2]) - int'(p2[3]);
    if (cen) begin
      mm = (mx != XI) || (my != YI);
      mx = XI; my = YI; runx = 0; runy = 0;
    end else if (tick) begin
      mm = (dx != 0) || (dy != 0);
      if (dx != 0) begin
        mx = wrap(mx + dx * step_of(runx, dirx, dx), H);
        runx = (runx > 0 && dirx == dx) ? ((runx >= 16) ? 16 : runx + 1) : 1;
        dirx = dx;
      end else runx = 0;
      if (dy != 0) begin
        my = wrap(my + dy * step_of(runy, diry, dy), V);
        runy = (runy > 0 && diry == dy) ? ((runy >= 16) ? 16 : runy + 1) : 1;
        diry = dy;
      end else runy = 0;
    end else begin
      mm = 1'b0;
    end
    p2 = p1;
    p1 = btn;
  endtask

  task automatic drive(input logic [3:0] btn, input logic tick, input logic cen);
    {BTN_SU, BTN_GIU, BTN_SX, BTN_DX} = btn;
    FRAME_TICK = tick;
    CENTRA = cen;
    @(posedge CLK);
    if (RST_N) model_edge(btn, tick, cen);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 12; i++) drive(4'($urandom), 1'b1, 1'b0);
    #2 RST_N = 1'b0;
    model_reset();
    #1;
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI), 1'b0}) begin
      bad++; $display("FAIL reset_async: got (%0d,%0d,%0b) want (%0d,%0d,0)", X_POS, Y_POS, MOSSO, XI, YI);
    end
    drive(B_DX, 1'b1, 1'b0);
    drive(B_DX, 1'b1, 1'b0);
    RST_N = 1'b1;
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI), 1'b0}) begin
      bad++; $display("FAIL reset_held: got (%0d,%0d,%0b) want (%0d,%0d,0)", X_POS, Y_POS, MOSSO, XI, YI);
    end
    for (int i = 0; i < 3; i++) drive(B_DX, 1'b0, 1'b0);
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI), 1'b0}) begin
      bad++; $display("FAIL reset_no_tick: got (%0d,%0d,%0b) want (%0d,%0d,0)", X_POS, Y_POS, MOSSO, XI, YI);
    end
  endtask

  task automatic test_right_wrap;
    int ex;
    drive(B_DX, 1'b0, 1'b1);
    drive(B_DX, 1'b0, 1'b0);
    for (int i = 0; i < 172; i++) drive(B_DX, 1'b1, 1'b0);
    ex = ACC ? mx : 1278;
    total++;
    if ({X_POS, Y_POS} !== {11'(ex), 11'(YI)}) begin
      bad++; $display("FAIL right_approach: got (%0d,%0d) want (%0d,%0d)", X_POS, Y_POS, ex, YI);
    end
    drive(B_DX, 1'b1, 1'b0);
    ex = ACC ? mx : 2;
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(ex), 11'(YI), 1'b1}) begin
      bad++; $display("FAIL right_wrap: got (%0d,%0d,%0b) want (%0d,%0d,1)", X_POS, Y_POS, MOSSO, ex, YI);
    end
    drive(B_DX, 1'b0, 1'b0);
    total++;
    if ({X_POS, MOSSO} !== {11'(ex), 1'b0}) begin
      bad++; $display("FAIL mosso_one_cycle: got (%0d,%0b) want (%0d,0)", X_POS, MOSSO, ex);
    end
  endtask

  task automatic test_up_wrap;
    int ey;
    drive(B_SU, 1'b0, 1'b1);
    drive(B_SU, 1'b0, 1'b0);
    for (int i = 0; i < 115; i++) drive(B_SU, 1'b1, 1'b0);
    ey = ACC ? my : 2;
    total++;
    if ({X_POS, Y_POS} !== {11'(XI), 11'(ey)}) begin
      bad++; $display("FAIL up_approach: got (%0d,%0d) want (%0d,%0d)", X_POS, Y_POS, XI, ey);
    end
    drive(B_SU, 1'b1, 1'b0);
    ey = ACC ? my : 1022;
    total++;
    if ({Y_POS, MOSSO} !== {11'(ey), 1'b1}) begin
      bad++; $display("FAIL up_wrap: got (%0d,%0b) want (%0d,1)", Y_POS, MOSSO, ey);
    end
    drive(B_SU, 1'b1, 1'b0);
    ey = ACC ? my : 1018;
    total++;
    if (Y_POS !== 11'(ey)) begin
      bad++; $display("FAIL up_after_wrap: got %0d want %0d", Y_POS, ey);
    end
  endtask

  task automatic test_opposite_diag;
    drive(B_SX | B_DX | B_GIU, 1'b0, 1'b1);
    drive(B_SX | B_DX | B_GIU, 1'b0, 1'b0);
    drive(B_SX | B_DX | B_GIU, 1'b1, 1'b0);
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI + P), 1'b1}) begin
      bad++; $display("FAIL diag_opposite: got (%0d,%0d,%0b) want (%0d,%0d,1)", X_POS, Y_POS, MOSSO, XI, YI + P);
    end
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0);
    drive(4'b1111, 1'b1, 1'b0);
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI + P), 1'b0}) begin
      bad++; $display("FAIL all_four: got (%0d,%0d,%0b) want (%0d,%0d,0)", X_POS, Y_POS, MOSSO, XI, YI + P);
    end
  endtask

  task automatic test_sync_priority;
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b1, 1'b0);
    total++;
    if ({X_POS, MOSSO} !== {11'(XI), 1'b0}) begin
      bad++; $display("FAIL sync_too_late: got (%0d,%0b) want (%0d,0)", X_POS, MOSSO, XI);
    end
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b1, 1'b0);
    total++;
    if ({X_POS, MOSSO} !== {11'(XI + P), 1'b1}) begin
      bad++; $display("FAIL sync_in_time: got (%0d,%0b) want (%0d,1)", X_POS, MOSSO, XI + P);
    end
    drive(B_DX, 1'b1, 1'b1);
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI), 1'b1}) begin
      bad++; $display("FAIL centra_over_tick: got (%0d,%0d,%0b) want (%0d,%0d,1)", X_POS, Y_POS, MOSSO, XI, YI);
    end
    drive(B_DX, 1'b1, 1'b1);
    total++;
    if ({X_POS, Y_POS, MOSSO} !== {11'(XI), 11'(YI), 1'b0}) begin
      bad++; $display("FAIL centra_no_change: got (%0d,%0d,%0b) want (%0d,%0d,0)", X_POS, Y_POS, MOSSO, XI, YI);
    end
  endtask

  task automatic test_accel;
    int ex;
    drive(4'd0, 1'b0, 1'b1);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(B_DX, 1'b1, 1'b0);
    ex = XI + (ACC ? 96 : 80);
    total++;
    if (X_POS !== 11'(ex)) begin
      bad++; $display("FAIL accel_20_ticks: got %0d want %0d", X_POS, ex);
    end
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b1, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b0, 1'b0);
    drive(B_DX, 1'b1, 1'b0);
    total++;
    if (X_POS !== 11'(ex + P)) begin
      bad++; $display("FAIL accel_restart: got %0d want %0d", X_POS, ex + P);
    end
  endtask

  task automatic test_random;
    logic [3:0] b;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) b = 4'($urandom);
      drive(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      total++;
      if ({X_POS, Y_POS, MOSSO} !== {11'(mx), 11'(my), mm}) begin
        bad++; $display("FAIL random[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,%0b)", i, X_POS, Y_POS, MOSSO, mx, my, mm);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; FRAME_TICK = 1'b0; CENTRA = 1'b0;
    {BTN_SU, BTN_GIU, BTN_SX, BTN_DX} = 4'd0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    test_reset();
    test_right_wrap();
    test_up_wrap();
    test_opposite_diag();
    test_sync_priority();
    test_accel();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muovi_posizione.md
Name: muovi_posizione

Overview:
- Position register stage that sits directly upstream of the rectangle/frame hit-test blocks.
- Owns the X_POS/Y_POS pair those blocks consume. Steps it once per video frame from four push-buttons.
- Wraps toroidally at H/V, matching the hit-test wrap semantics: X_POS in 0..H-1, Y_POS in 0..V-1.
- Updates only on the frame tick, so the shape never tears mid-frame.

Parameters:
H, 1280, horizontal active pixels; X_POS range 0..H-1
V, 1024, vertical active lines; Y_POS range 0..V-1
X_INIT, 590, reset/recentre X value; must be < H
Y_INIT, 462, reset/recentre Y value; must be < V
PASSO, 4, pixels moved per frame tick; 1 <= PASSO < V (and < H)

Ports:
CLK  input  1  pixel clock
RST_N  input  1  asynchronous active-low reset
FRAME_TICK  input  1  one-cycle pulse from timing generator at start of vertical blanking, synchronous to CLK
BTN_SU  input  1  raw button, active-high, asynchronous; move up (Y decreases)
BTN_GIU  input  1  raw button, active-high, asynchronous; move down (Y increases)
BTN_SX  input  1  raw button, active-high, asynchronous; move left (X decreases)
BTN_DX  input  1  raw button, active-high, asynchronous; move right (X increases)
CENTRA  input  1  synchronous pulse, restores X_INIT/Y_INIT
X_POS  output  11  current X position, registered
Y_POS  output  11  current Y position, registered
MOSSO  output  1  one-cycle pulse when X_POS or Y_POS changed

Behaviour:
- Reset (RST_N low, asynchronous):
  - X_POS=X_INIT, Y_POS=Y_INIT, MOSSO=0.
  - All synchronizer flops cleared to 0.
  - Release is synchronous to the next CLK edge.
  - Reset mid-frame discards any pending step.
- Button synchronization:
  - Each button passes through a 2-flop synchronizer.
  - The "synced" value used below is the second flop's output at the update edge, so button-to-effect latency is 2 CLK cycles plus wait for the next FRAME_TICK.
- Priority per rising edge of CLK:
  1. CENTRA=1: X_POS<=X_INIT, Y_POS<=Y_INIT. MOSSO<=1 only if either value differs from current. FRAME_TICK on the same edge is ignored.
  2. Else if FRAME_TICK=1: apply a step per axis (rules below). MOSSO<=1 if either axis changed, else 0.
  3. Else: hold X_POS/Y_POS; MOSSO<=0.
- X axis, from synced buttons:
  - DX only: X' = X_POS+PASSO. If X' >= H, X' -= H.
  - SX only: X' = X_POS-PASSO if X_POS >= PASSO, else X_POS+H-PASSO.
  - Both or neither pressed: no change.
- Y axis: same rules, GIU = increase, SU = decrease, modulus V.
- Arithmetic in 12-bit unsigned to avoid overflow before the compare; results are truncated to 11 bits only after wrap. Outputs never leave 0..H-1 / 0..V-1.
- Axes are independent; diagonal moves apply both steps on the same edge.
- A FRAME_TICK held high for multiple cycles steps once per high cycle. This is a caller error, not filtered.

Optional Feature:
- Macro: MUOVI_POSIZIONE_ACCEL_EN.
- Defined:
  - Per-axis 5-bit hold counter, incremented on each FRAME_TICK where that axis moves (clamped at 16).
  - Cleared on any FRAME_TICK where that axis does not move, or on a direction reversal, CENTRA, or reset.
  - When the counter is 16, that axis uses step 2*PASSO. Wrap rules are identical with 2*PASSO substituted; this requires 2*PASSO < V.
- Undefined: no counters; step is always PASSO.

Test Plan:
- Reset: hold RST_N low mid-stream, then release -> X_POS=590, Y_POS=462, MOSSO=0 immediately, no clock needed; no movement until a FRAME_TICK arrives with a synced button.
- Right wrap: X_POS=1278, BTN_DX held, FRAME_TICK -> X_POS=2, Y_POS unchanged, MOSSO pulses exactly 1 cycle.
- Up wrap: Y_POS=1, BTN_SU held, FRAME_TICK -> Y_POS=1021. Next tick -> 1017.
- Opposite buttons and diagonal:
  - BTN_SX and BTN_DX together plus BTN_GIU, tick from (590,462) -> (590,466), MOSSO=1.
  - All four buttons pressed -> no change, MOSSO=0.
- Sync latency and priority:
  - Button rises 1 cycle before FRAME_TICK -> no step on that tick.
  - Button rises 3 cycles before -> step.
  - CENTRA and FRAME_TICK on the same edge with BTN_DX -> (590,462), no step.
- MUOVI_POSIZIONE_ACCEL_EN: BTN_DX held for 20 ticks from X=0 -> steps 1-16 move 4 px each (X=64), steps 17-20 move 8 px each (X=96).
  - Release for one tick, then press again -> step returns to 4.
  - With macro undefined -> X=80 after 20 ticks.
